// File: rtl/qspi_flash_op_ctrl.sv
// Purpose: expands one read/erase/program request into WREN, op, RDSR-poll serializer commands.
// Latency: read ~ serializer time + 2; erase/program add WREN, GAP_CYCLES gaps and WIP polling.
// Backpressure: req_ready only in IDLE; each command holds ser_start until ser_dataready is seen.
module qspi_flash_op_ctrl #(
    parameter int          GAP_CYCLES = 16,
    parameter logic [31:0] POLL_MAX   = 32'd1000000,
    parameter int          ADDR_W     = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ser_start,
    input  logic              ser_busy,
    input  logic              ser_dataready,
    output logic [7:0]        ser_cmd,
    output logic [31:0]       ser_addr,
    output logic              ser_has_addr,
    output logic              ser_has_data,
    output logic              ser_wr,
    output logic [31:0]       ser_wdata,
    input  logic [31:0]       ser_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WREN = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_POLL = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_ERASE = 2'd1;
    localparam logic [1:0] OP_PROG  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_ERASE = 8'h20;
    localparam logic [7:0] CMD_PROG  = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    // Last gap count value before the next command may start.
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    logic [2:0]        r_state;
    logic [2:0]        r_after;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_gap_cnt;
    logic [31:0]       r_poll_cnt;
    logic              r_wip;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              r_ser_start;
    logic [7:0]        r_ser_cmd;
    logic [31:0]       r_ser_addr;
    logic              r_ser_has_addr;
    logic              r_ser_has_data;
    logic              r_ser_wr;
    logic [31:0]       r_ser_wdata;

    logic [2:0]        w_issue_state;
    logic [1:0]        w_issue_op;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [31:0]       w_issue_wdata;
    logic [7:0]        w_cmd;
    logic [31:0]       w_addr;
    logic              w_has_addr;
    logic              w_has_data;
    logic              w_wr;
    logic [31:0]       w_wdata;

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_rdata   = r_resp_rdata;
    assign ser_start    = r_ser_start;
    assign ser_cmd      = r_ser_cmd;
    assign ser_addr     = r_ser_addr;
    assign ser_has_addr = r_ser_has_addr;
    assign ser_has_data = r_ser_has_data;
    assign ser_wr       = r_ser_wr;
    assign ser_wdata    = r_ser_wdata;

    // Decode the command about to be issued: from the live request in IDLE, from the latched one in GAP.
    always_comb begin
        w_issue_op    = (r_state == S_IDLE) ? req_op    : r_op;
        w_issue_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
        w_issue_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
        w_issue_state = S_IDLE;
        if (r_state == S_IDLE) begin
            if (req_op == OP_READ) begin
                w_issue_state = S_OP;
            end else if (req_op == OP_RSVD) begin
                w_issue_state = S_RESP;
            end else begin
                w_issue_state = S_WREN;
            end
        end else if (r_state == S_GAP) begin
            w_issue_state = r_after;
        end
        w_cmd      = 8'h00;
        w_addr     = 32'h0;
        w_has_addr = 1'b0;
        w_has_data = 1'b0;
        w_wr       = 1'b0;
        w_wdata    = 32'h0;
        case (w_issue_state)
            S_WREN: w_cmd = CMD_WREN;
            S_OP: begin
                w_addr     = 32'(w_issue_addr);
                w_has_addr = 1'b1;
                case (w_issue_op)
                    OP_READ: begin
                        w_cmd      = CMD_READ;
                        w_has_data = 1'b1;
                    end
                    OP_ERASE: w_cmd = CMD_ERASE;
                    OP_PROG: begin
                        w_cmd      = CMD_PROG;
                        w_has_data = 1'b1;
                        w_wr       = 1'b1;
                        w_wdata    = w_issue_wdata;
                    end
                    default: w_has_addr = 1'b0;
                endcase
            end
            S_POLL: begin
                w_cmd      = CMD_RDSR;
                w_has_data = 1'b1;
            end
            default: w_cmd = 8'h00;
        endcase
    end

    // Sequencer: accept, issue each command with start/dataready handshake, gap, poll, respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_after        <= S_IDLE;
            r_op           <= 2'd0;
            r_addr         <= '0;
            r_wdata        <= 32'h0;
            r_gap_cnt      <= 32'h0;
            r_poll_cnt     <= 32'h0;
            r_wip          <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_rdata   <= 32'h0;
            r_ser_start    <= 1'b0;
            r_ser_cmd      <= 8'h00;
            r_ser_addr     <= 32'h0;
            r_ser_has_addr <= 1'b0;
            r_ser_has_data <= 1'b0;
            r_ser_wr       <= 1'b0;
            r_ser_wdata    <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op         <= req_op;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_gap_cnt    <= 32'h0;
                        r_poll_cnt   <= 32'h0;
                        r_wip        <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= 1'b0;
                        if (req_op == OP_RSVD) begin
                            // Reserved op never touches the serializer.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state        <= w_issue_state;
                            r_ser_start    <= 1'b1;
                            r_ser_cmd      <= w_cmd;
                            r_ser_addr     <= w_addr;
                            r_ser_has_addr <= w_has_addr;
                            r_ser_has_data <= w_has_data;
                            r_ser_wr       <= w_wr;
                            r_ser_wdata    <= w_wdata;
                        end
                    end
                end
                S_WREN, S_OP, S_POLL: begin
                    if (r_ser_start) begin
                        if (ser_dataready) begin
                            r_ser_start <= 1'b0;
                            if (r_state == S_OP && r_op == OP_READ) begin
                                r_resp_rdata <= ser_rdata;
                            end
                            if (r_state == S_POLL) begin
                                r_wip <= ser_rdata[0];
                            end
                        end
                    end else if (!ser_busy) begin
                        // Command fully retired by the serializer.
                        r_gap_cnt <= 32'h0;
                        if (r_state == S_WREN) begin
                            r_state <= S_GAP;
                            r_after <= S_OP;
                        end else if (r_state == S_OP) begin
                            if (r_op == OP_READ) begin
                                r_state      <= S_RESP;
                                r_resp_valid <= 1'b1;
                            end else begin
                                r_state <= S_GAP;
                                r_after <= S_POLL;
                            end
                        end else if (!r_wip) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end else if ((r_poll_cnt + 32'd1) >= POLL_MAX) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 32'd1;
                            r_state    <= S_GAP;
                            r_after    <= S_POLL;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state        <= r_after;
                        r_ser_start    <= 1'b1;
                        r_ser_cmd      <= w_cmd;
                        r_ser_addr     <= w_addr;
                        r_ser_has_addr <= w_has_addr;
                        r_ser_has_data <= w_has_data;
                        r_ser_wr       <= w_wr;
                        r_ser_wdata    <= w_wdata;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
